shift_reg: RTL and testbench
============================

# shift_reg

Parallel-load, serial-out shift register. Loads a WIDTH-bit word in one clock, then emits it MSB-first on a single-bit output, one bit per clock, backfilling from a serial input. Sits between a word-wide producer and a bit-serial consumer (serializer front end, pattern generator, serial link TX).

## Interface

One clock; reset is asynchronous and active-low.

Parameters:
- WIDTH, default 8: register length in bits; legal range WIDTH >= 1.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- i_bit  input  1  serial fill bit; enters at LSB on every shift.
- i_fill  input  WIDTH  parallel load word.
- i_fill_en  input  1  parallel load enable; loads i_fill when high.
- o_out  output  1  serial output; always equals the register MSB.

## Operation

- State: one WIDTH-bit register `sr`.
- Reset (rst_n low): `sr` cleared to all zeros immediately, independent of clk; o_out = 0. Held while rst_n low.
- Each rising clk edge with rst_n high:
  - i_fill_en = 1: `sr <= i_fill` (load). Load has priority; no shift that cycle.
  - i_fill_en = 0: `sr <= {sr[WIDTH-2:0], i_bit}` (shift toward MSB, i_bit into LSB).
- o_out = `sr[WIDTH-1]`, driven combinationally from the register only; no combinational path from any input to o_out.
- No idle/hold mode: every non-load cycle shifts.
- WIDTH = 1: load writes the single bit; shift replaces it with i_bit.
- i_fill_en held high on consecutive cycles: reloads each cycle; o_out stays i_fill[WIDTH-1] of the latest sampled word.
- Load asserted mid-stream: abandons remaining bits; new word takes effect at that edge.
- Reset asserted mid-stream: contents lost; after release, o_out stays 0 until a load, or until a 1 on i_bit has shifted WIDTH positions.

## Timing

- Load latency: o_out = i_fill[WIDTH-1] valid right after the loading edge.
- After the load edge, k-th subsequent shift edge (k = 1..WIDTH-1): o_out = i_fill[WIDTH-1-k].
- After WIDTH shifts: o_out = value of i_bit sampled at the first shift edge; i_bit values then appear in the order sampled, WIDTH cycles late.
- Inputs sampled on rising edge only; setup/hold relative to clk.
- Reset deassertion: first active edge is the first rising edge after rst_n goes high; synchronize the release externally.

## Test plan

- Reset: rst_n low with clk running, i_fill_en=1, i_fill=8'hFF -> o_out = 0 throughout; releasing rst_n then one edge -> o_out = 1.
- Load and drain (WIDTH=8): load 8'b10011010 with i_bit=0, then i_fill_en=0 -> o_out after successive edges = 1,0,0,1,1,0,1,0, then 0 every cycle thereafter.
- Backfill: load 8'h00, then shift with i_bit=1 -> o_out 0 for 7 shift edges, 1 from the 8th shift edge on.
- Reload priority: load 8'hF0, shift 2 cycles (o_out 1,1,1), then i_fill_en=1 with i_fill=8'h0F -> o_out = 0 at that edge, then 0,0,0,1,1,1,1.
- Continuous load: i_fill_en=1 every cycle with i_fill alternating 8'h80/8'h00 -> o_out toggles 1,0,1,0 one edge after each word.
- Async reset mid-stream: load 8'hFF, shift 3, assert rst_n between edges -> o_out drops to 0 before the next clk edge.

Source files
------------

// File: rtl/shift_reg_if.sv
// -----------------------------------------------------------------------------
// shift_reg_if
//
// Bundles the word-side and bit-side signals of the parallel-load, serial-out
// shift register so that producer and register connect through one port.
//
// Handshake: there is no valid/ready pair on this link. The register accepts
// i_fill on every rising edge where i_fill_en is high, and it shifts on every
// other edge. o_out is always meaningful; the consumer samples one bit per
// clock. The producer is therefore responsible for pacing loads, because
// nothing back-pressures it.
//
// Signals:
//   i_bit      producer -> register  serial fill bit, enters at the LSB on a shift
//   i_fill     producer -> register  WIDTH-bit parallel load word
//   i_fill_en  producer -> register  load enable; a load has priority over a shift
//   o_out      register -> consumer  serial output, always the register MSB
//
// Modports:
//   master  the word-wide producer / serial consumer side
//   slave   the shift register itself
// -----------------------------------------------------------------------------
interface shift_reg_if #(
  parameter int WIDTH = 8
);

  logic             i_bit;
  logic [WIDTH-1:0] i_fill;
  logic             i_fill_en;
  logic             o_out;

  modport master (
    output i_bit,
    output i_fill,
    output i_fill_en,
    input  o_out
  );

  modport slave (
    input  i_bit,
    input  i_fill,
    input  i_fill_en,
    output o_out
  );

endinterface : shift_reg_if

// File: rtl/shift_reg.sv
// -----------------------------------------------------------------------------
// shift_reg
//
// Parallel-load, serial-out shift register. A WIDTH-bit word is loaded in one
// clock, then emitted MSB-first on o_out, one bit per clock. The vacated LSB
// is back-filled from i_bit on every shift.
//
// Parameters:
//   WIDTH  register length in bits (WIDTH >= 1)
//
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset; clears the register to zero
//   bus    shift_reg_if.slave carrying i_bit, i_fill, i_fill_en, o_out
//
// Behaviour on each rising edge, with rst_n high:
//   i_fill_en = 1 : sr <= i_fill                    (load; no shift this cycle)
//   i_fill_en = 0 : sr <= {sr[WIDTH-2:0], i_bit}    (shift toward the MSB)
// There is no hold mode: every edge that is not a load is a shift.
//
// o_out is taken straight from the register MSB, so there is no combinational
// path from any input to the output.
// -----------------------------------------------------------------------------
module shift_reg #(
  parameter int WIDTH = 8
) (
  input  logic      clk,
  input  logic      rst_n,
  shift_reg_if.slave bus
);

  logic [WIDTH-1:0] sr;
  logic [WIDTH-1:0] shift_next;
  logic [WIDTH-1:0] sr_next;

  // The shifted value is built in a generate so that WIDTH = 1 never
  // elaborates the empty slice sr[WIDTH-2:0]; a one-bit register simply
  // takes i_bit on a shift.
  generate
    if (WIDTH == 1) begin : g_single
      assign shift_next = bus.i_bit;
    end else begin : g_multi
      assign shift_next = {sr[WIDTH-2:0], bus.i_bit};
    end
  endgenerate

  // Load wins over shift.
  always_comb begin
    sr_next = shift_next;
    if (bus.i_fill_en) begin
      sr_next = bus.i_fill;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr <= '0;
    end else begin
      sr <= sr_next;
    end
  end

  assign bus.o_out = sr[WIDTH-1];

endmodule : shift_reg

// File: tb/tb_shift_reg.sv
// -----------------------------------------------------------------------------
// tb_shift_reg
//
// Directed bench for shift_reg. An 8-bit instance carries the main sequence;
// a 1-bit instance covers the single-bit corner. Expected o_out values are
// hand-computed constants or bits of the word that was loaded.
// Inputs change 1 ns after a rising edge; outputs are sampled there too.
// -----------------------------------------------------------------------------
module tb_shift_reg;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic clk;
  logic rst_n;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // DUTs
  // ---------------------------------------------------------------------------
  shift_reg_if #(.WIDTH(8)) bus8 ();
  shift_reg_if #(.WIDTH(1)) bus1 ();

  shift_reg #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus8)
  );

  shift_reg #(.WIDTH(1)) dut1 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus1)
  );

  // ---------------------------------------------------------------------------
  // Scoreboard counters and checking task
  // ---------------------------------------------------------------------------
  int n_cmp;
  int n_err;

  task automatic check_val(input string tag, input logic [7:0] got,
                           input logic [7:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Driver tasks
  // ---------------------------------------------------------------------------
  // Advance to just after the next rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic load8(input logic [7:0] word);
    bus8.i_fill_en = 1'b1;
    bus8.i_fill    = word;
    step();
    bus8.i_fill_en = 1'b0;
  endtask

  task automatic shift8(input logic b);
    bus8.i_fill_en = 1'b0;
    bus8.i_bit     = b;
    step();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  logic [7:0] word;

  initial begin
    n_cmp = 0;
    n_err = 0;

    rst_n          = 1'b0;
    bus8.i_bit     = 1'b0;
    bus8.i_fill    = 8'hFF;
    bus8.i_fill_en = 1'b1;
    bus1.i_bit     = 1'b0;
    bus1.i_fill    = 1'b1;
    bus1.i_fill_en = 1'b1;

    // Reset held with load requested: output must stay 0.
    #1;
    check_val("rst_hold_t0", {7'd0, bus8.o_out}, 8'd0);
    check_val("rst_hold_w1", {7'd0, bus1.o_out}, 8'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      check_val("rst_hold", {7'd0, bus8.o_out}, 8'd0);
    end
    rst_n = 1'b1;
    check_val("rst_release_no_edge", {7'd0, bus8.o_out}, 8'd0);
    step();
    check_val("rst_release_load", {7'd0, bus8.o_out}, 8'd1);
    check_val("w1_load_1", {7'd0, bus1.o_out}, 8'd1);

    // WIDTH=1: shift replaces the bit, load has priority over i_bit.
    bus1.i_fill_en = 1'b0;
    bus1.i_bit     = 1'b0;
    bus8.i_fill_en = 1'b0;
    step();
    check_val("w1_shift_0", {7'd0, bus1.o_out}, 8'd0);
    bus1.i_bit = 1'b1;
    step();
    check_val("w1_shift_1", {7'd0, bus1.o_out}, 8'd1);
    bus1.i_fill_en = 1'b1;
    bus1.i_fill    = 1'b0;
    step();
    check_val("w1_load_prio", {7'd0, bus1.o_out}, 8'd0);
    bus1.i_fill_en = 1'b0;

    // Load and drain 8'b10011010, zero backfill.
    word = 8'b1001_1010;
    bus8.i_bit = 1'b0;
    load8(word);
    check_val("drain_load", {7'd0, bus8.o_out}, {7'd0, word[7]});
    for (int k = 1; k < 8; k++) begin
      shift8(1'b0);
      check_val("drain_bit", {7'd0, bus8.o_out}, {7'd0, word[7-k]});
    end
    for (int k = 0; k < 3; k++) begin
      shift8(1'b0);
      check_val("drain_zero_fill", {7'd0, bus8.o_out}, 8'd0);
    end

    // Backfill: ones appear on the 8th shift edge.
    load8(8'h00);
    check_val("fill_load", {7'd0, bus8.o_out}, 8'd0);
    for (int k = 1; k < 8; k++) begin
      shift8(1'b1);
      check_val("fill_wait", {7'd0, bus8.o_out}, 8'd0);
    end
    shift8(1'b1);
    check_val("fill_8th", {7'd0, bus8.o_out}, 8'd1);
    shift8(1'b1);
    check_val("fill_9th", {7'd0, bus8.o_out}, 8'd1);

    // Reload mid-stream: 0F replaces F0 after two shifts.
    load8(8'hF0);
    check_val("reload_f0", {7'd0, bus8.o_out}, 8'd1);
    shift8(1'b0);
    check_val("reload_s1", {7'd0, bus8.o_out}, 8'd1);
    shift8(1'b0);
    check_val("reload_s2", {7'd0, bus8.o_out}, 8'd1);
    word = 8'h0F;
    load8(word);
    check_val("reload_0f", {7'd0, bus8.o_out}, 8'd0);
    for (int k = 1; k < 8; k++) begin
      shift8(1'b0);
      check_val("reload_drain", {7'd0, bus8.o_out}, {7'd0, word[7-k]});
    end

    // Continuous load alternating 80/00.
    bus8.i_bit     = 1'b1;
    bus8.i_fill_en = 1'b1;
    for (int k = 0; k < 4; k++) begin
      bus8.i_fill = (k % 2 == 0) ? 8'h80 : 8'h00;
      step();
      check_val("cont_load", {7'd0, bus8.o_out}, (k % 2 == 0) ? 8'd1 : 8'd0);
    end
    bus8.i_fill_en = 1'b0;

    // Async reset mid-stream.
    load8(8'hFF);
    for (int k = 0; k < 3; k++) begin
      shift8(1'b0);
      check_val("async_pre", {7'd0, bus8.o_out}, 8'd1);
    end
    #2;
    rst_n = 1'b0;
    #1;
    check_val("async_drop", {7'd0, bus8.o_out}, 8'd0);
    step();
    rst_n = 1'b1;
    check_val("async_held", {7'd0, bus8.o_out}, 8'd0);
    for (int k = 0; k < 3; k++) begin
      shift8(1'b0);
      check_val("async_after", {7'd0, bus8.o_out}, 8'd0);
    end

    // After reset, a single 1 on i_bit surfaces exactly 8 shifts later.
    shift8(1'b1);
    check_val("single_one_s1", {7'd0, bus8.o_out}, 8'd0);
    for (int k = 2; k < 8; k++) begin
      shift8(1'b0);
      check_val("single_one_wait", {7'd0, bus8.o_out}, 8'd0);
    end
    shift8(1'b0);
    check_val("single_one_out", {7'd0, bus8.o_out}, 8'd1);
    shift8(1'b0);
    check_val("single_one_gone", {7'd0, bus8.o_out}, 8'd0);

    // Final report
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule : tb_shift_reg
